// File: rtl/frame_swap_sched.sv
// -----------------------------------------------------------------------------
// frame_swap_sched
//
// Display buffer swap scheduler. Round-robin arbitration between NREQ render
// clients, each asking for "display buffer X". A grant raises buf_swap towards
// the timing generator for PULSE_LEN cycles, then the block waits for the
// frame to finish before acking the granted client and updating the front
// buffer index. Single clock domain (clk).
//
// Optional feature macro: SWAP_TIMEOUT_EN
//   defined   : WAIT-state watchdog of TIMEOUT cycles; an expired watchdog
//               retires the swap without changing front_idx and sets err.
//   undefined : WAIT waits indefinitely; err is tied low, err_clr unused.
//
// Ports
//   clk        in   clock
//   rst_n      in   asynchronous reset, active-low
//   swap_en    in   gates new grants only; a swap in progress completes
//   req        in   [NREQ]        per-client level request, held until ack
//   req_buf    in   [NREQ*BUF_W]  requested buffer index, client i at [i*BUF_W +: BUF_W]
//   frame_end  in   1-cycle frame-finished pulse (already in clk domain)
//   err_clr    in   clears err (watchdog build only)
//   buf_swap   out  swap request to the timing generator
//   ack        out  [NREQ]        1-cycle pulse to the client whose swap retired
//   owner      out  index of the client granted last / currently
//   busy       out  high in any state other than IDLE
//   front_idx  out  [BUF_W]       buffer currently displayed
//   err        out  sticky watchdog flag
// -----------------------------------------------------------------------------
module frame_swap_sched #(
  parameter int NREQ      = 2,
  parameter int BUF_W     = 2,
  parameter int PULSE_LEN = 4,
  parameter int TIMEOUT   = 1000000,
  parameter int TO_W      = 20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      swap_en,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*BUF_W-1:0]     req_buf,
  input  logic                      frame_end,
  input  logic                      err_clr,
  output logic                      buf_swap,
  output logic [NREQ-1:0]           ack,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy,
  output logic [BUF_W-1:0]          front_idx,
  output logic                      err
);

  localparam int OW  = $clog2(NREQ);
  localparam int PCW = $clog2(PULSE_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e             state_r, state_nxt_s;
  logic               buf_swap_r, buf_swap_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic [OW-1:0]      owner_r, owner_nxt_s;
  logic [NREQ-1:0]    ack_r, ack_nxt_s;
  logic [BUF_W-1:0]   front_r, front_nxt_s;
  logic [BUF_W-1:0]   pend_r, pend_nxt_s;
  logic [OW-1:0]      rr_ptr_r, rr_ptr_nxt_s;
  logic [PCW-1:0]     pcnt_r, pcnt_nxt_s;

  // Arbitration helpers
  logic [2*NREQ-1:0]  req2_s;
  logic [NREQ-1:0]    req_rot_s;
  logic [OW-1:0]      off_s;
  logic [OW:0]        sum_s;
  logic [OW-1:0]      winner_s;
  logic [OW-1:0]      winner_inc_s;
  logic [BUF_W-1:0]   winner_buf_s;

`ifdef SWAP_TIMEOUT_EN
  logic [TO_W-1:0]    to_cnt_r, to_cnt_nxt_s;
  logic               err_r, err_nxt_s;
  logic               timeout_s;
`else
  logic               unused_err_clr_s;
  assign unused_err_clr_s = err_clr;
`endif

  // Rotate the request vector so that bit 0 is the client at the RR pointer;
  // the lowest set bit of the rotated vector is then the winner's offset.
  assign req2_s    = {req, req};
  assign req_rot_s = NREQ'(req2_s >> rr_ptr_r);

  // Priority search over the rotated request vector (lowest offset wins)
  always_comb begin
    off_s = {OW{1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot_s[k]) begin
        off_s = OW'(k);
      end else begin
        off_s = off_s;
      end
    end
  end

  // Undo the rotation: winner = (rr_ptr + offset) mod NREQ, both operands < NREQ
  always_comb begin
    sum_s = {1'b0, rr_ptr_r} + {1'b0, off_s};
    if (sum_s >= (OW+1)'(NREQ)) begin
      winner_s = OW'(sum_s - (OW+1)'(NREQ));
    end else begin
      winner_s = OW'(sum_s);
    end
  end

  // Pointer after the winner and the winner's requested buffer index
  always_comb begin
    if (winner_s == OW'(NREQ - 1)) begin
      winner_inc_s = {OW{1'b0}};
    end else begin
      winner_inc_s = winner_s + OW'(1);
    end
    winner_buf_s = BUF_W'(req_buf >> (int'(winner_s) * BUF_W));
  end

  // Next-state and next-output logic for the IDLE -> PULSE -> WAIT sequence
  always_comb begin
    state_nxt_s    = state_r;
    buf_swap_nxt_s = buf_swap_r;
    busy_nxt_s     = busy_r;
    owner_nxt_s    = owner_r;
    ack_nxt_s      = {NREQ{1'b0}};
    front_nxt_s    = front_r;
    pend_nxt_s     = pend_r;
    rr_ptr_nxt_s   = rr_ptr_r;
    pcnt_nxt_s     = pcnt_r;
`ifdef SWAP_TIMEOUT_EN
    to_cnt_nxt_s   = to_cnt_r;
    timeout_s      = 1'b0;
`endif

    case (state_r)
      ST_IDLE: begin
        if (swap_en && (|req)) begin
          state_nxt_s    = ST_PULSE;
          buf_swap_nxt_s = 1'b1;
          busy_nxt_s     = 1'b1;
          owner_nxt_s    = winner_s;
          pend_nxt_s     = winner_buf_s;
          rr_ptr_nxt_s   = winner_inc_s;
          pcnt_nxt_s     = {PCW{1'b0}};
        end else begin
          state_nxt_s    = ST_IDLE;
          buf_swap_nxt_s = 1'b0;
          busy_nxt_s     = 1'b0;
        end
      end

      // frame_end seen here belongs to the frame before the swap: ignored
      ST_PULSE: begin
        if (pcnt_r == PCW'(PULSE_LEN - 1)) begin
          state_nxt_s    = ST_WAIT;
          buf_swap_nxt_s = 1'b0;
`ifdef SWAP_TIMEOUT_EN
          to_cnt_nxt_s   = {TO_W{1'b0}};
`endif
        end else begin
          pcnt_nxt_s     = pcnt_r + PCW'(1);
        end
      end

      ST_WAIT: begin
        if (frame_end) begin
          // Normal retire; frame_end takes precedence over a coincident timeout
          state_nxt_s = ST_IDLE;
          busy_nxt_s  = 1'b0;
          front_nxt_s = pend_r;
          ack_nxt_s   = {{(NREQ-1){1'b0}}, 1'b1} << owner_r;
        end
`ifdef SWAP_TIMEOUT_EN
        else if (to_cnt_r == TO_W'(TIMEOUT - 1)) begin
          // Watchdog retire: the client is released but the display is untouched
          state_nxt_s = ST_IDLE;
          busy_nxt_s  = 1'b0;
          ack_nxt_s   = {{(NREQ-1){1'b0}}, 1'b1} << owner_r;
          timeout_s   = 1'b1;
        end else begin
          to_cnt_nxt_s = to_cnt_r + TO_W'(1);
        end
`else
        else begin
          state_nxt_s = ST_WAIT;
        end
`endif
      end

      default: begin
        state_nxt_s    = ST_IDLE;
        buf_swap_nxt_s = 1'b0;
        busy_nxt_s     = 1'b0;
      end
    endcase
  end

`ifdef SWAP_TIMEOUT_EN
  // Sticky error flag; a clear request wins over a coincident new timeout
  always_comb begin
    if (err_clr) begin
      err_nxt_s = 1'b0;
    end else if (timeout_s) begin
      err_nxt_s = 1'b1;
    end else begin
      err_nxt_s = err_r;
    end
  end

  // Watchdog counter and error flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r <= {TO_W{1'b0}};
      err_r    <= 1'b0;
    end else begin
      to_cnt_r <= to_cnt_nxt_s;
      err_r    <= err_nxt_s;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  // State and registered-output flops; reset aborts any swap with no ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      buf_swap_r <= 1'b0;
      busy_r     <= 1'b0;
      owner_r    <= {OW{1'b0}};
      ack_r      <= {NREQ{1'b0}};
      front_r    <= {BUF_W{1'b0}};
      pend_r     <= {BUF_W{1'b0}};
      rr_ptr_r   <= {OW{1'b0}};
      pcnt_r     <= {PCW{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      buf_swap_r <= buf_swap_nxt_s;
      busy_r     <= busy_nxt_s;
      owner_r    <= owner_nxt_s;
      ack_r      <= ack_nxt_s;
      front_r    <= front_nxt_s;
      pend_r     <= pend_nxt_s;
      rr_ptr_r   <= rr_ptr_nxt_s;
      pcnt_r     <= pcnt_nxt_s;
    end
  end

  assign buf_swap  = buf_swap_r;
  assign busy      = busy_r;
  assign owner     = owner_r;
  assign ack       = ack_r;
  assign front_idx = front_r;

endmodule

// File: tb/tb_frame_swap_sched.sv
// -----------------------------------------------------------------------------
// tb_frame_swap_sched
//
// Directed bench for frame_swap_sched with NREQ=2, BUF_W=2, PULSE_LEN=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// The watchdog scenario is only exercised when SWAP_TIMEOUT_EN is defined
// (TIMEOUT=16).
// -----------------------------------------------------------------------------
module tb_frame_swap_sched;

  localparam int NREQ      = 2;
  localparam int BUF_W     = 2;
  localparam int PULSE_LEN = 4;
  localparam int TIMEOUT   = 16;
  localparam int TO_W      = 5;

  logic                  clk       = 1'b0;
  logic                  rst_n     = 1'b0;
  logic                  swap_en   = 1'b0;
  logic [NREQ-1:0]       req       = 2'b00;
  logic [NREQ*BUF_W-1:0] req_buf   = 4'b0000;
  logic                  frame_end = 1'b0;
  logic                  err_clr   = 1'b0;
  logic                  buf_swap;
  logic [NREQ-1:0]       ack;
  logic [0:0]            owner;
  logic                  busy;
  logic [BUF_W-1:0]      front_idx;
  logic                  err;

  int n_cmp = 0;
  int n_bad = 0;

  frame_swap_sched #(
    .NREQ      (NREQ),
    .BUF_W     (BUF_W),
    .PULSE_LEN (PULSE_LEN),
    .TIMEOUT   (TIMEOUT),
    .TO_W      (TO_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .swap_en   (swap_en),
    .req       (req),
    .req_buf   (req_buf),
    .frame_end (frame_end),
    .err_clr   (err_clr),
    .buf_swap  (buf_swap),
    .ack       (ack),
    .owner     (owner),
    .busy      (busy),
    .front_idx (front_idx),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Count buf_swap-high cycles from the current sample point (already = cycles
  // consumed by the caller) and confirm the block then sits in WAIT.
  task automatic pulse_phase(input string tag, input int already);
    int hcnt;
    hcnt = already;
    while (buf_swap === 1'b1 && hcnt < 4 * PULSE_LEN) begin
      hcnt++;
      tick();
    end
    chk({tag, "_pulse_len"}, hcnt, PULSE_LEN);
    chk({tag, "_busy_in_wait"}, {31'd0, busy}, 32'd1);
  endtask

  // Finish the pulse, wait wait_n WAIT cycles, pulse frame_end, check retire
  task automatic retire(input string tag, input int already, input int wait_n,
                        input logic [1:0] exp_ack, input logic [1:0] exp_front);
    pulse_phase(tag, already);
    repeat (wait_n) tick();
    chk({tag, "_no_early_ack"}, {30'd0, ack}, 32'd0);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk({tag, "_ack"}, {30'd0, ack}, {30'd0, exp_ack});
    chk({tag, "_front"}, {30'd0, front_idx}, {30'd0, exp_front});
    chk({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst_buf_swap", {31'd0, buf_swap}, 32'd0);
    chk("rst_ack", {30'd0, ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_owner", {31'd0, owner}, 32'd0);
    chk("rst_front", {30'd0, front_idx}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;

    // ---- 1: single request from client 0 for buffer 2 ----
    swap_en = 1'b1;
    req     = 2'b01;
    req_buf = 4'b0010;
    tick();
    chk("t1_grant_swap", {31'd0, buf_swap}, 32'd1);
    chk("t1_owner", {31'd0, owner}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    retire("t1", 0, 9, 2'b01, 2'd2);
    req = 2'b00;
    tick();
    chk("t1_ack_one_cycle", {30'd0, ack}, 32'd0);
    chk("t1_no_regrant", {31'd0, buf_swap}, 32'd0);

    // ---- 2: both clients held, grants alternate (pointer now at client 1) ----
    req     = 2'b11;
    req_buf = 4'b1101;
    tick();
    chk("t2a_owner", {31'd0, owner}, 32'd1);
    retire("t2a", 0, 3, 2'b10, 2'd3);
    tick();
    chk("t2b_rerise", {31'd0, buf_swap}, 32'd1);
    chk("t2b_owner", {31'd0, owner}, 32'd0);
    retire("t2b", 0, 2, 2'b01, 2'd1);
    tick();
    chk("t2c_rerise", {31'd0, buf_swap}, 32'd1);
    chk("t2c_owner", {31'd0, owner}, 32'd1);
    retire("t2c", 0, 0, 2'b10, 2'd3);
    req = 2'b00;
    tick();
    chk("t2_idle", {31'd0, busy}, 32'd0);

    // ---- 3: frame_end during PULSE ignored; req dropped after grant ----
    req     = 2'b01;
    req_buf = 4'b1100;
    tick();
    chk("t3_owner", {31'd0, owner}, 32'd0);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    req       = 2'b00;
    chk("t3_fe_in_pulse_ack", {30'd0, ack}, 32'd0);
    chk("t3_fe_in_pulse_swap", {31'd0, buf_swap}, 32'd1);
    retire("t3", 1, 4, 2'b01, 2'd0);

    // ---- 4: swap_en gating ----
    swap_en = 1'b0;
    req     = 2'b10;
    req_buf = 4'b1000;
    repeat (3) tick();
    chk("t4_blocked_swap", {31'd0, buf_swap}, 32'd0);
    chk("t4_blocked_busy", {31'd0, busy}, 32'd0);
    swap_en = 1'b1;
    tick();
    chk("t4_grant", {31'd0, buf_swap}, 32'd1);
    chk("t4_owner", {31'd0, owner}, 32'd1);
    swap_en = 1'b0;
    retire("t4", 0, 3, 2'b10, 2'd2);
    req     = 2'b00;
    swap_en = 1'b1;
    tick();

    // ---- 5: reset during PULSE aborts with no ack ----
    req     = 2'b01;
    req_buf = 4'b0011;
    tick();
    chk("t5_grant", {31'd0, buf_swap}, 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_swap", {31'd0, buf_swap}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_front", {30'd0, front_idx}, 32'd0);
    req = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_no_ack", {30'd0, ack}, 32'd0);
    chk("t5_front_after", {30'd0, front_idx}, 32'd0);
    req = 2'b11;
    tick();
    chk("t5_ptr_reset_owner", {31'd0, owner}, 32'd0);
    retire("t5", 0, 1, 2'b01, 2'd3);
    req = 2'b00;
    tick();

`ifdef SWAP_TIMEOUT_EN
    // ---- 6: watchdog expiry, err_clr, and frame_end on the expiry cycle ----
    req     = 2'b01;
    req_buf = 4'b0001;
    tick();
    req = 2'b00;
    pulse_phase("t6a", 1);
    repeat (TIMEOUT - 1) tick();
    chk("t6a_no_ack_yet", {30'd0, ack}, 32'd0);
    tick();
    chk("t6a_to_ack", {30'd0, ack}, 32'd1);
    chk("t6a_err", {31'd0, err}, 32'd1);
    chk("t6a_front_kept", {30'd0, front_idx}, 32'd3);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t6a_err_clr", {31'd0, err}, 32'd0);
    req     = 2'b01;
    req_buf = 4'b0010;
    tick();
    req = 2'b00;
    pulse_phase("t6b", 1);
    repeat (TIMEOUT - 1) tick();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("t6b_ack", {30'd0, ack}, 32'd1);
    chk("t6b_front", {30'd0, front_idx}, 32'd2);
    chk("t6b_no_err", {31'd0, err}, 32'd0);
`else
    chk("t6_err_tied", {31'd0, err}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
